// File: rtl/vic_tile_shifter_if.sv
// rtl/vic_tile_shifter_if.sv - tile/pattern/colour RAM fetch bus between the shifter and video memories
interface vic_tile_shifter_if #(
    parameter int PAL_BITS = 2
);
    logic [9:0]          vram_addr;
    logic [7:0]          vram_data;
    logic [10:0]         char_addr;
    logic [7:0]          char_data;
    logic [PAL_BITS+2:0] color_addr;
    logic [7:0]          color_data;

    modport master (
        output vram_addr, char_addr, color_addr,
        input  vram_data, char_data, color_data
    );

    modport slave (
        input  vram_addr, char_addr, color_addr,
        output vram_data, char_data, color_data
    );
endinterface

// File: rtl/vic_tile_shifter.sv
// rtl/vic_tile_shifter.sv - per-cell tile fetch and MSB-first pixel serialiser with blanking
// Optional FLIP_SCREEN_EN adds a flip input that mirrors addressing and shifts LSB-first.
module vic_tile_shifter #(
    parameter int PAL_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce_pix,
    input  logic [8:0]          hcnt,
    input  logic [8:0]          vcnt,
    input  logic                hblank,
    input  logic                vblank,
    input  logic [PAL_BITS-1:0] palette,
`ifdef FLIP_SCREEN_EN
    input  logic                flip,
`endif
    vic_tile_shifter_if.master  mem,
    output logic [2:0]          rgb,
    output logic                blank_out
);

    logic [9:0]          vram_addr_q, vram_addr_d;
    logic [10:0]         char_addr_q, char_addr_d;
    logic [PAL_BITS+2:0] color_addr_q, color_addr_d;
    logic [7:0]          code_r_q, code_r_d;
    logic [7:0]          pat_r_q, pat_r_d;
    logic [7:0]          col_r_q, col_r_d;
    logic [7:0]          shift_r_q, shift_r_d;
    logic [2:0]          fg_q, fg_d;
    logic [2:0]          bg_q, bg_d;
    logic [2:0]          rgb_q, rgb_d;
    logic                blank_out_q, blank_out_d;

    logic       flip_en;
    logic [2:0] phase;
    logic       fetch_en;
    logic [4:0] col_n;
    logic [4:0] col;
    logic [4:0] row;
    logic [2:0] line;
    logic       pix_bit;
    logic       blank_now;
    logic       unused_bits;

`ifdef FLIP_SCREEN_EN
    assign flip_en = flip;
`else
    assign flip_en = 1'b0;
`endif

    assign unused_bits = ^{vcnt[8], col_r_q[4], col_r_q[0]};

    // Visible cells fetch one column ahead; cell 40 (hcnt 320..327) prefetches column 0 of the next line.
    always_comb begin
        phase     = hcnt[2:0];
        fetch_en  = ~hcnt[8] | (hcnt[7:3] == 5'd8);
        col_n     = hcnt[8] ? 5'd0 : hcnt[7:3] + 5'd1;
        col       = flip_en ? ~col_n : col_n;
        row       = flip_en ? ~vcnt[7:3] : vcnt[7:3];
        line      = flip_en ? ~vcnt[2:0] : vcnt[2:0];
        pix_bit   = flip_en ? shift_r_q[0] : shift_r_q[7];
        blank_now = hblank | vblank;
    end

    always_comb begin
        vram_addr_d  = vram_addr_q;
        char_addr_d  = char_addr_q;
        color_addr_d = color_addr_q;
        code_r_d     = code_r_q;
        pat_r_d      = pat_r_q;
        col_r_d      = col_r_q;
        shift_r_d    = shift_r_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        rgb_d        = rgb_q;
        blank_out_d  = blank_out_q;
        if (ce_pix) begin
            blank_out_d = blank_now;
            rgb_d       = blank_now ? 3'd0 : (pix_bit ? fg_q : bg_q);
            // The p=7 load is unconditional; whatever it picks up outside fetch cells is blanked anyway.
            if (phase == 3'd7) begin
                shift_r_d = pat_r_q;
                fg_d      = col_r_q[3:1];
                bg_d      = col_r_q[7:5];
            end else begin
                shift_r_d = flip_en ? (shift_r_q >> 1) : (shift_r_q << 1);
            end
            if (fetch_en) begin
                case (phase)
                    3'd0: vram_addr_d = {row, col};
                    3'd2: begin
                        code_r_d     = mem.vram_data;
                        char_addr_d  = {mem.vram_data, line};
                        color_addr_d = {palette, mem.vram_data[7:5]};
                    end
                    3'd4: begin
                        pat_r_d = mem.char_data;
                        col_r_d = mem.color_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr_q  <= '0;
            char_addr_q  <= '0;
            color_addr_q <= '0;
            code_r_q     <= '0;
            pat_r_q      <= '0;
            col_r_q      <= '0;
            shift_r_q    <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            rgb_q        <= '0;
            blank_out_q  <= 1'b1;
        end else begin
            vram_addr_q  <= vram_addr_d;
            char_addr_q  <= char_addr_d;
            color_addr_q <= color_addr_d;
            code_r_q     <= code_r_d;
            pat_r_q      <= pat_r_d;
            col_r_q      <= col_r_d;
            shift_r_q    <= shift_r_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            rgb_q        <= rgb_d;
            blank_out_q  <= blank_out_d;
        end
    end

    assign mem.vram_addr  = vram_addr_q;
    assign mem.char_addr  = char_addr_q;
    assign mem.color_addr = color_addr_q;
    assign rgb            = rgb_q;
    assign blank_out      = blank_out_q;

endmodule

// File: tb/tb_vic_tile_shifter.sv
// tb/tb_vic_tile_shifter.sv - directed bench for vic_tile_shifter with synchronous RAM models
module tb_vic_tile_shifter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ce_pix = 1'b0;
    logic [8:0] hcnt = '0;
    logic [8:0] vcnt = '0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic [1:0] palette = '0;
    logic [2:0] rgb;
    logic       blank_out;
`ifdef FLIP_SCREEN_EN
    logic       flip = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] vram [0:1023];
    logic [7:0] cram [0:2047];
    logic [7:0] prom [0:31];
    logic [2:0] rgb_log [0:327];
    logic       bo_log  [0:327];

    vic_tile_shifter_if #(.PAL_BITS(2)) m ();

    vic_tile_shifter #(.PAL_BITS(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hblank    (hblank),
        .vblank    (vblank),
        .palette   (palette),
`ifdef FLIP_SCREEN_EN
        .flip      (flip),
`endif
        .mem       (m),
        .rgb       (rgb),
        .blank_out (blank_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m.vram_data  <= vram[m.vram_addr];
        m.char_data  <= cram[m.char_addr];
        m.color_data <= prom[m.color_addr];
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One pixel-clock enable at the current hcnt, then an idle clock; returns on a negedge.
    task automatic step(input int h);
        hcnt   = h[8:0];
        ce_pix = 1'b1;
        @(negedge clk);
        ce_pix = 1'b0;
        @(negedge clk);
        rgb_log[h] = rgb;
        bo_log[h]  = blank_out;
    endtask

    logic [2:0] exp_cell3 [0:7];
    logic [2:0] exp_cell0 [0:7];

    initial begin
        exp_cell3 = '{3'd6, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6};
        exp_cell0 = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
        for (int i = 0; i < 1024; i++) vram[i] = 8'h10;
        for (int i = 0; i < 2048; i++) cram[i] = 8'h00;
        for (int i = 0; i < 32; i++)   prom[i] = 8'h00;
        vram[10'h043] = 8'hA5;
        vram[10'h045] = 8'hE7;
        vram[10'h04C] = 8'hA5;
        vram[10'h020] = 8'h3C;
        cram[{8'hA5, 3'd3}] = 8'h81;
        cram[{8'hE7, 3'd3}] = 8'hFF;
        cram[{8'h3C, 3'd0}] = 8'hF0;
        prom[{2'd2, 3'd5}] = 8'h2C;
        prom[{2'd1, 3'd5}] = 8'h2C;
        prom[{2'd1, 3'd7}] = 8'h0E;
        prom[{2'd0, 3'd1}] = 8'hA4;

        #1 reset_n = 1'b0;
        #2;
        check("reset_rgb", rgb, 0);
        check("reset_blank_out", blank_out, 1);
        check("reset_vram_addr", m.vram_addr, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Row 2 line 3: addressing, pixel order, palette change, blanking.
        vcnt = 9'd19;
        palette = 2'd2;
        for (int h = 8; h <= 47; h++) begin
            if (h >= 19) palette = 2'd1;
            hblank = (h >= 40 && h <= 43);
            vblank = (h == 44 || h == 45);
            step(h);
            if (h == 16) check("vram_addr_r2c3", m.vram_addr, 10'h043);
            if (h == 18) begin
                check("char_addr_a5", m.char_addr, 11'h52B);
                check("color_addr_pal2", m.color_addr, 5'h15);
            end
            if (h == 26) check("color_addr_pal1", m.color_addr, 5'h08);
        end
        hblank = 1'b0;
        vblank = 1'b0;
        check("rgb_before_cell3", rgb_log[23], 0);
        for (int k = 0; k < 8; k++) check($sformatf("cell3_px%0d", k), rgb_log[24 + k], exp_cell3[k]);
        check("hblank_rgb", rgb_log[41], 0);
        check("hblank_blank_out", bo_log[41], 1);
        check("vblank_rgb", rgb_log[44], 0);
        check("vblank_blank_out", bo_log[44], 1);
        check("unblank_rgb", rgb_log[46], 7);
        check("unblank_blank_out", bo_log[46], 0);

        // End of line: last visible fetch wraps to column 0, idle cells hold, then next-line prefetch.
        palette = 2'd0;
        vcnt = 9'd31;
        for (int h = 248; h <= 327; h++) begin
            if (h == 272) vcnt = 9'd8;
            hblank = (h >= 256);
            step(h);
            if (h == 248) check("vram_addr_h248", m.vram_addr, 10'h060);
            if (h == 256) check("vram_addr_hold", m.vram_addr, 10'h060);
            if (h == 320) check("vram_addr_prefetch", m.vram_addr, 10'h020);
        end
        check("prefetch_blanked_rgb", rgb_log[326], 0);
        hblank = 1'b0;
        for (int h = 0; h <= 7; h++) step(h);
        for (int k = 0; k < 8; k++) check($sformatf("cell0_px%0d", k), rgb_log[k], exp_cell0[k]);

`ifdef FLIP_SCREEN_EN
        flip = 1'b1;
        vcnt = 9'd0;
        step(0);
        check("flip_vram_addr", m.vram_addr, 10'h3FE);
        flip = 1'b0;
`endif

        // Asynchronous reset in the middle of a displayed cell.
        vcnt = 9'd19;
        palette = 2'd1;
        for (int h = 88; h <= 100; h++) step(h);
        check("pre_reset_px96", rgb_log[96], 6);
        check("pre_reset_px100", rgb_log[100], 1);
        check("pre_reset_vram_addr", m.vram_addr, 10'h04D);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_rgb", rgb, 0);
        check("async_reset_blank_out", blank_out, 1);
        check("async_reset_vram_addr", m.vram_addr, 0);
        check("async_reset_char_addr", m.char_addr, 0);
        check("async_reset_color_addr", m.color_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
